// File: rtl/ifid_queue_pkg.sv
// rtl/ifid_queue_pkg.sv - shared fetch/decode pipeline constants and fetch-entry type
package ifid_queue_pkg;

  localparam int          DEF_PC_W    = 16;
  localparam int          DEF_INSTR_W = 16;
  localparam logic [15:0] NOP_ENC     = 16'hb000;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc4;
    logic [DEF_INSTR_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/ifid_queue_mem.sv
// rtl/ifid_queue_mem.sv - entry storage, synchronous write and asynchronous indexed read
module ifid_queue_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifid_queue.sv
// rtl/ifid_queue.sv - DEPTH-entry FWFT queue between fetch and decode with flush bubble
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int                 PC_W      = DEF_PC_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_ENC),
  parameter int                 AF_LEVEL  = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       if_valid,
  input  logic [PC_W-1:0]            if_pc4,
  input  logic [INSTR_W-1:0]         if_instruction,
  output logic                       if_ready,
  output logic                       if_almost_full,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc4,
  output logic [INSTR_W-1:0]         id_instruction,
  output logic                       id_flushed,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INSTR_W;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          flushed_q, flushed_d;
  logic          wr_en, rd_en;
  logic [EW-1:0] head;

  // if_ready/id_valid derive from count only, so ID stalls never reach IF combinationally
  assign if_ready       = (count_q != CW'(DEPTH));
  assign id_valid       = (count_q != '0);
  assign if_almost_full = (count_q >= CW'(AF_LEVEL));
  assign count          = count_q;
  assign id_flushed     = flushed_q;

  assign wr_en = if_valid && if_ready && !flush;
  assign rd_en = id_valid && id_ready && !flush;

  ifid_queue_mem #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({if_pc4, if_instruction}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign id_pc4         = id_valid ? head[EW-1:INSTR_W] : '0;
  assign id_instruction = id_valid ? head[INSTR_W-1:0]  : NOP_INSTR;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    flushed_d = flush;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      flushed_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      flushed_q <= flushed_d;
    end
  end

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry first-word-fall-through queue between fetch and decode.
- Decouples IF from ID stalls with a valid/ready handshake.
- Flush discards all entries and produces a bubble (NOP) to ID.
- Sits between the fetch unit and the decode stage of the 16-bit pipeline.

Parameters:
- PC_W, 16, width of the PC+4 field
- INSTR_W, 16, width of the instruction field
- DEPTH, 4, number of entries; power of two, >= 2
- NOP_INSTR, 16'hb000, instruction word presented to ID when no valid entry exists
- AF_LEVEL, DEPTH-1, occupancy at or above which if_almost_full asserts

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-high
- if_valid  in  1  IF presents an entry
- if_pc4  in  PC_W  PC+4 from IF
- if_instruction  in  INSTR_W  fetched instruction
- if_ready  out  1  queue accepts a write this cycle
- if_almost_full  out  1  count >= AF_LEVEL
- flush  in  1  branch/jump flush request from EX
- id_ready  in  1  ID consumes the head entry this cycle (low = ID stall)
- id_valid  out  1  head entry valid
- id_pc4  out  PC_W  head PC+4; 0 when !id_valid
- id_instruction  out  INSTR_W  head instruction; NOP_INSTR when !id_valid
- id_flushed  out  1  one-cycle marker: the bubble now at ID results from a flush
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State: DEPTH x (PC_W+INSTR_W) storage, wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap naturally, count, id_flushed register. Storage is not reset.
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, id_flushed=0. Outputs during and after reset: if_ready=1, if_almost_full=0 (if AF_LEVEL>0), id_valid=0, id_pc4=0, id_instruction=NOP_INSTR.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- if_ready = (count != DEPTH). It is registered-state only, with no combinational path from id_ready.
- Write: if_valid && if_ready && !flush. Data goes to storage[wr_ptr]; wr_ptr+1.
- Read: id_valid && id_ready && !flush. rd_ptr+1.
- FWFT:
  - id_valid = (count != 0).
  - id_pc4 and id_instruction come from storage[rd_ptr] when valid.
  - Otherwise they carry the constants above, selected combinationally from state.
  - Latency from IF write to ID visibility is 1 cycle.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous read and write, which is legal when 0 < count < DEPTH.
- Full: a write is refused even if id_ready=1 in the same cycle; no pass-through when full.
- Empty: id_ready is ignored and pointers are unchanged. When count=0, a write and a read in the same cycle produce no read (the head is not yet visible).
- Flush (synchronous, highest priority after reset):
  - On a clock edge with flush=1: wr_ptr=rd_ptr=0 and count=0.
  - Any concurrent write and read are discarded.
  - id_flushed=1 for exactly the following cycle, during which id_valid=0 and id_instruction=NOP_INSTR.
- id_flushed clears on the next edge unless flush is still high. A continuous flush keeps the queue empty and id_flushed high.
- The first write after flush is accepted on the edge following flush deassertion.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0. Full and empty are distinguished only by count.

Decomposition:
- Shared pipeline package holds:
  - NOP encoding constant (16'hb000)
  - default PC/instruction widths
  - a typedef for the {pc4, instruction} fetch-entry struct, reused by later stage registers
- One natural sub-module, ifid_queue_mem: DEPTH x entry storage with synchronous write and asynchronous read by index.
- Pointer, count and flush control remain in ifid_queue.

Test Plan:
- Reset: assert reset_n between edges → outputs go immediately to id_valid=0, id_instruction=16'hb000, id_pc4=0, count=0, if_ready=1.
- Single pass: write {pc4=16'h0002, instr=16'h1234} with id_ready=0 → next cycle id_valid=1, id_instruction=16'h1234, count=1. Then id_ready=1 → count=0 and the NOP is shown.
- Fill/full (DEPTH=4): write 4 entries with id_ready=0 → count=4, if_ready=0, if_almost_full=1. A 5th write is held. Drain 4 → entries come out in order with no loss.
- Wrap plus simultaneous read/write: sustain 10 writes with id_ready=1 from cycle 2 → count stays 1, ID sees all 10 entries in order, pointers wrap twice.
- Flush with pending entries: count=3, assert flush together with if_valid=1 and id_ready=1 → next cycle count=0, id_flushed=1, id_instruction=16'hb000. The concurrent write is absent. id_flushed=0 one cycle later.
- Stall then flush: fill to full with id_ready=0, pulse flush → if_ready=1 next cycle. A write in the following cycle appears at ID one cycle later.
